// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared types and constants for the external-bus arbiter
package ext_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  typedef enum logic {M_A, M_B} master_t;
  localparam logic [15:0] OOR_DATA = 16'hDEAD;
  localparam int WAIT_W = 4;
endpackage

// File: rtl/ext_bus_ram.sv
// ext_bus_ram: single-port word RAM with per-byte write enables and registered read
module ext_bus_ram #(
  parameter int DW = 16,
  parameter int DEPTH = 256,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [IW-1:0] addr,
  input  logic [1:0]    we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  // byte-lane writes and read-before-write registered output; contents are never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (we[i]) mem[addr][i*(DW/2) +: DW/2] <= wdata[i*(DW/2) +: DW/2];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: round-robin arbitration of two bus masters onto a shared word RAM with mailbox irq
module ext_bus_arbiter
  import ext_bus_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 11,
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 2,
  parameter logic [AW-2:0] MBOX_ADDR = 10'h0FF
) (
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic          a_bus_enable,
  input  logic          a_rw,
  input  logic [AW-1:0] a_address,
  input  logic [1:0]    a_byte_enable,
  input  logic [DW-1:0] a_write_data,
  output logic [DW-1:0] a_read_data,
  output logic          a_acknowledge,
  output logic          a_irq,
  input  logic          b_bus_enable,
  input  logic          b_rw,
  input  logic [AW-1:0] b_address,
  input  logic [1:0]    b_byte_enable,
  input  logic [DW-1:0] b_write_data,
  output logic [DW-1:0] b_read_data,
  output logic          b_acknowledge,
  output logic          grant_b
);
  localparam int IW = $clog2(DEPTH);
  state_t state;
  master_t last_grant, owner, win;
  logic [WAIT_W-1:0] cnt;
  logic lat_rw, pick_b, in_range, done, unused_lsb;
  logic [AW-2:0] lat_idx, win_idx;
  logic [1:0] lat_be, ram_we;
  logic [DW-1:0] lat_wd, ram_q, rdata;
  assign unused_lsb = a_address[0] ^ b_address[0];
  // winner selection, range check and RAM control; RAM is addressed by the winner while idle so
  // the read is already in flight on the grant edge
  always_comb begin
    pick_b = b_bus_enable && (!a_bus_enable || last_grant == M_A);
    win = pick_b ? M_B : M_A;
    win_idx = pick_b ? b_address[AW-1:1] : a_address[AW-1:1];
    in_range = 32'(lat_idx) < DEPTH;
    done = state == ACCESS && cnt == '0;
    ram_we = (done && !lat_rw && in_range && !reset_reset) ? lat_be : 2'b00;
    rdata = in_range ? ram_q : DW'(OOR_DATA);
  end
  ext_bus_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
    .clk(clk_clk),
    .addr(IW'(state == IDLE ? win_idx : lat_idx)),
    .we(ram_we),
    .wdata(lat_wd),
    .rdata(ram_q)
  );
  // arbitration FSM with registered acknowledges, read data, grant flag and mailbox irq
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= M_B;
      owner <= M_A;
      lat_rw <= 1'b0;
      lat_idx <= '0;
      lat_be <= '0;
      lat_wd <= '0;
      a_acknowledge <= 1'b0;
      b_acknowledge <= 1'b0;
      a_read_data <= '0;
      b_read_data <= '0;
      a_irq <= 1'b0;
      grant_b <= 1'b0;
    end else begin
      case (state)
        IDLE: if (a_bus_enable || b_bus_enable) begin
          state <= ACCESS;
          owner <= win;
          last_grant <= win;
          grant_b <= pick_b;
          lat_rw <= pick_b ? b_rw : a_rw;
          lat_idx <= win_idx;
          lat_be <= pick_b ? b_byte_enable : a_byte_enable;
          lat_wd <= pick_b ? b_write_data : a_write_data;
          cnt <= WAIT_W'(WAIT_CYCLES - 1);
        end
        ACCESS: if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          state <= ACK;
          a_acknowledge <= owner == M_A;
          b_acknowledge <= owner == M_B;
          if (owner == M_A) a_read_data <= rdata;
          else b_read_data <= rdata;
          if (lat_idx == MBOX_ADDR) a_irq <= owner == M_B ? (lat_rw ? a_irq : 1'b1) : 1'b0;
        end
        ACK: begin
          state <= IDLE;
          a_acknowledge <= 1'b0;
          b_acknowledge <= 1'b0;
          grant_b <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
